// File: rtl/sorted_book_pkg.sv
// Shared types for the sorted order book: op/status/FSM encodings and the resting-order entry.
package sorted_book_pkg;

   localparam int SB_PRICE_W = 32;
   localparam int SB_QTY_W   = 16;
   localparam int SB_ID_W    = 32;

   typedef enum logic [1:0] {
      OP_ADD     = 2'd0,
      OP_CANCEL  = 2'd1,
      OP_EXECUTE = 2'd2,
      OP_INVALID = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      STS_OK        = 2'd0,
      STS_FULL      = 2'd1,
      STS_NOT_FOUND = 2'd2,
      STS_BAD_OP    = 2'd3
   } status_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIND  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      WR_INSERT = 2'd0,
      WR_REMOVE = 2'd1,
      WR_REDUCE = 2'd2
   } wr_op_t;

   typedef struct packed {
      logic [SB_PRICE_W-1:0] price;
      logic [SB_QTY_W-1:0]   qty;
      logic [SB_ID_W-1:0]    id;
   } entry_t;

endpackage

// File: rtl/book_side_array.sv
// One side (bid or ask) of the book for every stock: sorted storage, parallel search, shift/insert.
// Optional debug read port when SORTED_BOOK_DBG_EN is defined.
module book_side_array
   import sorted_book_pkg::*;
#(
   parameter int NUM_STOCKS = 4,
   parameter int BOOK_DEPTH = 8,
   parameter bit IS_BID     = 1'b1,
   parameter int SID_W      = 2,
   parameter int IDX_W      = 3,
   parameter int CNT_W      = 4
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [SID_W-1:0] i_stock,
   input  entry_t           i_entry,
   input  logic             i_wr_en,
   input  wr_op_t           i_wr_op,
   input  logic [CNT_W-1:0] i_wr_idx,
   output logic [CNT_W-1:0] o_count,
   output logic [CNT_W-1:0] o_ins_idx,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx,
   output logic [SB_QTY_W-1:0] o_rest_qty,
   output entry_t           o_best
`ifdef SORTED_BOOK_DBG_EN
   ,
   input  logic [SID_W-1:0] dbg_stock,
   input  logic [IDX_W-1:0] dbg_slot,
   output entry_t           o_dbg_entry,
   output logic [CNT_W-1:0] o_dbg_count
`endif
);

   entry_t           r_book  [NUM_STOCKS][BOOK_DEPTH];
   logic [CNT_W-1:0] r_count [NUM_STOCKS];

   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] w_ins_idx;
   logic             w_found;
   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_wr_slot;

   assign w_wr_slot = i_wr_idx[IDX_W-1:0];

   // Scan from the top slot down so the last hit is the lowest matching slot.
   always_comb begin
      w_cnt     = r_count[i_stock];
      w_ins_idx = w_cnt;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int k = BOOK_DEPTH - 1; k >= 0; k--) begin
         if (k < int'(w_cnt)) begin
            if (IS_BID ? (r_book[i_stock][k].price < i_entry.price)
                       : (r_book[i_stock][k].price > i_entry.price))
               w_ins_idx = CNT_W'(k);
            if (r_book[i_stock][k].id == i_entry.id) begin
               w_found = 1'b1;
               w_idx   = IDX_W'(k);
            end
         end
      end
   end

   assign o_count    = w_cnt;
   assign o_ins_idx  = w_ins_idx;
   assign o_found    = w_found;
   assign o_idx      = w_idx;
   assign o_rest_qty = r_book[i_stock][w_idx].qty;
   assign o_best     = r_book[i_stock][0];

   // Slots at or above count are kept zero so removal can shift blindly.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int s = 0; s < NUM_STOCKS; s++) begin
            r_count[s] <= '0;
            for (int k = 0; k < BOOK_DEPTH; k++)
               r_book[s][k] <= '0;
         end
      end else if (i_wr_en) begin
         unique case (i_wr_op)
            WR_INSERT: begin
               for (int k = 1; k < BOOK_DEPTH; k++)
                  if (k > int'(i_wr_idx))
                     r_book[i_stock][k] <= r_book[i_stock][k-1];
               r_book[i_stock][w_wr_slot] <= i_entry;
               r_count[i_stock] <= r_count[i_stock] + CNT_W'(1);
            end
            WR_REMOVE: begin
               for (int k = 0; k < BOOK_DEPTH - 1; k++)
                  if (k >= int'(i_wr_idx))
                     r_book[i_stock][k] <= r_book[i_stock][k+1];
               r_book[i_stock][BOOK_DEPTH-1] <= '0;
               r_count[i_stock] <= r_count[i_stock] - CNT_W'(1);
            end
            WR_REDUCE: begin
               r_book[i_stock][w_wr_slot].qty <= r_book[i_stock][w_wr_slot].qty - i_entry.qty;
            end
            default: ;
         endcase
      end
   end

`ifdef SORTED_BOOK_DBG_EN
   assign o_dbg_entry = r_book[dbg_stock][dbg_slot];
   assign o_dbg_count = r_count[dbg_stock];
`endif

endmodule

// File: rtl/sorted_order_book.sv
// Per-stock, per-side price-time sorted order book with ADD/CANCEL/EXECUTE over valid/ready.
// Define SORTED_BOOK_DBG_EN to add a combinational debug read port for any slot.
//
// state    | meaning
// ST_IDLE  | o_ready high, op fields captured on i_valid
// ST_FIND  | parallel search of selected stock/side, decision registered
// ST_WRITE | book updated (shift/insert/reduce) when the decision allows
// ST_DONE  | o_done pulse, best-of-book taken from the updated book
module sorted_order_book
   import sorted_book_pkg::*;
#(
   parameter  int NUM_STOCKS = 4,
   parameter  int BOOK_DEPTH = 8,
   parameter  int PRICE_W    = SB_PRICE_W,
   parameter  int QTY_W      = SB_QTY_W,
   parameter  int ID_W       = SB_ID_W,
   localparam int SID_W      = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
   localparam int IDX_W      = (BOOK_DEPTH > 1) ? $clog2(BOOK_DEPTH) : 1,
   localparam int CNT_W      = $clog2(BOOK_DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [1:0]         i_order_type,
   input  logic               i_side,
   input  logic [SID_W-1:0]   i_stock_id,
   input  logic [QTY_W-1:0]   i_quantity,
   input  logic [PRICE_W-1:0] i_price,
   input  logic [ID_W-1:0]    i_order_id,
   output logic               o_done,
   output logic [1:0]         o_status,
   output logic [QTY_W-1:0]   o_filled_qty,
   output logic [SID_W-1:0]   o_stock_id,
   output logic [PRICE_W-1:0] o_best_bid,
   output logic [QTY_W-1:0]   o_best_bid_qty,
   output logic               o_bid_valid,
   output logic [PRICE_W-1:0] o_best_ask,
   output logic [QTY_W-1:0]   o_best_ask_qty,
   output logic               o_ask_valid
`ifdef SORTED_BOOK_DBG_EN
   ,
   input  logic               dbg_side,
   input  logic [SID_W-1:0]   dbg_stock,
   input  logic [IDX_W-1:0]   dbg_slot,
   output logic [PRICE_W-1:0] dbg_price,
   output logic [QTY_W-1:0]   dbg_qty,
   output logic [ID_W-1:0]    dbg_id,
   output logic [CNT_W-1:0]   dbg_count
`endif
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BOOK_DEPTH);

   state_t             r_state, w_state_nxt;
   op_t                r_op;
   logic               r_side;
   logic [SID_W-1:0]   r_stock;
   logic [QTY_W-1:0]   r_qty;
   logic [PRICE_W-1:0] r_price;
   logic [ID_W-1:0]    r_id;

   status_t            r_status, w_status;
   logic [QTY_W-1:0]   r_fill, w_fill;
   logic               r_wr_en, w_wr_en;
   wr_op_t             r_wr_op, w_wr_op;
   logic [CNT_W-1:0]   r_idx, w_wr_idx;

   status_t            r_o_status;
   logic [QTY_W-1:0]   r_o_fill;
   logic [SID_W-1:0]   r_o_sid;
   logic [PRICE_W-1:0] r_hold_bb, r_hold_ba, w_live_bb, w_live_ba;
   logic [QTY_W-1:0]   r_hold_bbq, r_hold_baq, w_live_bbq, w_live_baq;
   logic               r_hold_bv, r_hold_av;

   entry_t             w_entry;
   logic [CNT_W-1:0]   w_bid_cnt, w_ask_cnt, w_bid_ins, w_ask_ins, w_cnt, w_ins_idx;
   logic               w_bid_found, w_ask_found, w_found;
   logic [IDX_W-1:0]   w_bid_idx, w_ask_idx, w_idx;
   logic [QTY_W-1:0]   w_bid_rest, w_ask_rest, w_rest;
   entry_t             w_bid_best, w_ask_best;
   logic               w_bid_wr, w_ask_wr;

   assign w_entry  = '{price: r_price, qty: r_qty, id: r_id};
   assign w_bid_wr = (r_state == ST_WRITE) && r_wr_en && r_side;
   assign w_ask_wr = (r_state == ST_WRITE) && r_wr_en && !r_side;

`ifdef SORTED_BOOK_DBG_EN
   entry_t           w_bid_dbg, w_ask_dbg;
   logic [CNT_W-1:0] w_bid_dbg_cnt, w_ask_dbg_cnt;
`endif

   book_side_array #(
      .NUM_STOCKS(NUM_STOCKS), .BOOK_DEPTH(BOOK_DEPTH), .IS_BID(1'b1),
      .SID_W(SID_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) u_bid (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stock(r_stock), .i_entry(w_entry),
      .i_wr_en(w_bid_wr), .i_wr_op(r_wr_op), .i_wr_idx(r_idx),
      .o_count(w_bid_cnt), .o_ins_idx(w_bid_ins), .o_found(w_bid_found),
      .o_idx(w_bid_idx), .o_rest_qty(w_bid_rest), .o_best(w_bid_best)
`ifdef SORTED_BOOK_DBG_EN
      , .dbg_stock(dbg_stock), .dbg_slot(dbg_slot),
      .o_dbg_entry(w_bid_dbg), .o_dbg_count(w_bid_dbg_cnt)
`endif
   );

   book_side_array #(
      .NUM_STOCKS(NUM_STOCKS), .BOOK_DEPTH(BOOK_DEPTH), .IS_BID(1'b0),
      .SID_W(SID_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) u_ask (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stock(r_stock), .i_entry(w_entry),
      .i_wr_en(w_ask_wr), .i_wr_op(r_wr_op), .i_wr_idx(r_idx),
      .o_count(w_ask_cnt), .o_ins_idx(w_ask_ins), .o_found(w_ask_found),
      .o_idx(w_ask_idx), .o_rest_qty(w_ask_rest), .o_best(w_ask_best)
`ifdef SORTED_BOOK_DBG_EN
      , .dbg_stock(dbg_stock), .dbg_slot(dbg_slot),
      .o_dbg_entry(w_ask_dbg), .o_dbg_count(w_ask_dbg_cnt)
`endif
   );

`ifdef SORTED_BOOK_DBG_EN
   assign dbg_price = dbg_side ? w_bid_dbg.price : w_ask_dbg.price;
   assign dbg_qty   = dbg_side ? w_bid_dbg.qty   : w_ask_dbg.qty;
   assign dbg_id    = dbg_side ? w_bid_dbg.id    : w_ask_dbg.id;
   assign dbg_count = dbg_side ? w_bid_dbg_cnt   : w_ask_dbg_cnt;
`endif

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      o_ready     = 1'b0;
      o_done      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) w_state_nxt = ST_FIND;
         end
         ST_FIND:  w_state_nxt = ST_WRITE;
         ST_WRITE: w_state_nxt = ST_DONE;
         ST_DONE: begin
            o_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Zero-quantity ADD/EXECUTE is an accepted no-op, checked before FULL/NOT_FOUND.
   always_comb begin
      w_cnt     = r_side ? w_bid_cnt   : w_ask_cnt;
      w_ins_idx = r_side ? w_bid_ins   : w_ask_ins;
      w_found   = r_side ? w_bid_found : w_ask_found;
      w_idx     = r_side ? w_bid_idx   : w_ask_idx;
      w_rest    = r_side ? w_bid_rest  : w_ask_rest;
      w_status  = STS_OK;
      w_fill    = '0;
      w_wr_en   = 1'b0;
      w_wr_op   = WR_INSERT;
      w_wr_idx  = '0;
      unique case (r_op)
         OP_ADD: begin
            if (r_qty == '0) begin
               w_status = STS_OK;
            end else if (w_cnt == FULL_CNT) begin
               w_status = STS_FULL;
            end else begin
               w_wr_en  = 1'b1;
               w_wr_idx = w_ins_idx;
            end
         end
         OP_CANCEL: begin
            if (!w_found) begin
               w_status = STS_NOT_FOUND;
            end else begin
               w_wr_en  = 1'b1;
               w_wr_op  = WR_REMOVE;
               w_wr_idx = CNT_W'(w_idx);
            end
         end
         OP_EXECUTE: begin
            if (r_qty == '0) begin
               w_status = STS_OK;
            end else if (!w_found) begin
               w_status = STS_NOT_FOUND;
            end else begin
               w_wr_en  = 1'b1;
               w_wr_idx = CNT_W'(w_idx);
               if (r_qty >= w_rest) begin
                  w_wr_op = WR_REMOVE;
                  w_fill  = w_rest;
               end else begin
                  w_wr_op = WR_REDUCE;
                  w_fill  = r_qty;
               end
            end
         end
         default: w_status = STS_BAD_OP;
      endcase
   end

   always_comb begin
      w_live_bb  = (w_bid_cnt != '0) ? w_bid_best.price : '0;
      w_live_bbq = (w_bid_cnt != '0) ? w_bid_best.qty   : '0;
      w_live_ba  = (w_ask_cnt != '0) ? w_ask_best.price : '1;
      w_live_baq = (w_ask_cnt != '0) ? w_ask_best.qty   : '0;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_op       <= OP_ADD;
         r_side     <= 1'b0;
         r_stock    <= '0;
         r_qty      <= '0;
         r_price    <= '0;
         r_id       <= '0;
         r_status   <= STS_OK;
         r_fill     <= '0;
         r_wr_en    <= 1'b0;
         r_wr_op    <= WR_INSERT;
         r_idx      <= '0;
         r_o_status <= STS_OK;
         r_o_fill   <= '0;
         r_o_sid    <= '0;
         r_hold_bb  <= '0;
         r_hold_bbq <= '0;
         r_hold_bv  <= 1'b0;
         r_hold_ba  <= '1;
         r_hold_baq <= '0;
         r_hold_av  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (i_valid) begin
                  r_op    <= op_t'(i_order_type);
                  r_side  <= i_side;
                  r_stock <= i_stock_id;
                  r_qty   <= i_quantity;
                  r_price <= i_price;
                  r_id    <= i_order_id;
               end
            end
            ST_FIND: begin
               r_status <= w_status;
               r_fill   <= w_fill;
               r_wr_en  <= w_wr_en;
               r_wr_op  <= w_wr_op;
               r_idx    <= w_wr_idx;
            end
            ST_WRITE: begin
               r_o_status <= r_status;
               r_o_fill   <= r_fill;
               r_o_sid    <= r_stock;
            end
            ST_DONE: begin
               r_hold_bb  <= w_live_bb;
               r_hold_bbq <= w_live_bbq;
               r_hold_bv  <= (w_bid_cnt != '0);
               r_hold_ba  <= w_live_ba;
               r_hold_baq <= w_live_baq;
               r_hold_av  <= (w_ask_cnt != '0);
            end
            default: ;
         endcase
      end
   end

   // In DONE the book already holds the result, so best-of-book is read live, then held.
   always_comb begin
      o_status     = r_o_status;
      o_filled_qty = r_o_fill;
      o_stock_id   = r_o_sid;
      if (r_state == ST_DONE) begin
         o_best_bid     = w_live_bb;
         o_best_bid_qty = w_live_bbq;
         o_bid_valid    = (w_bid_cnt != '0);
         o_best_ask     = w_live_ba;
         o_best_ask_qty = w_live_baq;
         o_ask_valid    = (w_ask_cnt != '0);
      end else begin
         o_best_bid     = r_hold_bb;
         o_best_bid_qty = r_hold_bbq;
         o_bid_valid    = r_hold_bv;
         o_best_ask     = r_hold_ba;
         o_best_ask_qty = r_hold_baq;
         o_ask_valid    = r_hold_av;
      end
   end

endmodule
